// File: rtl/spi_reg_master_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: frame geometry,
// register-file read wait and the frame state encoding.
package spi_reg_master_pkg;

  localparam int CMD_BITS  = 8;
  localparam int DATA_BITS = 16;
  localparam int LOAD_WAIT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    LOAD   = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  // STAGES must be at least 2 for the chain concatenation below.
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 slave that turns 24-bit host frames into one register-file read
// (returned on MISO) and an optional write committed at frame end.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [7:0]           adr_out,
  output logic [DATA_BITS-1:0] data_wr,
  output logic                 wr_enable,
  input  logic [DATA_BITS-1:0] data_rd,
  output logic [7:0]           frame_err_cnt,
  output logic                 busy,
  output state_t               fsm_state
);

  localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
  localparam logic [1:0] LOAD_LAST  = 2'(LOAD_WAIT - 1);

  logic sclk_rise, sclk_fall, sclk_q;
  logic cs_rise, cs_fall, cs_q;
  logic mosi_q;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .din   (sclk),
    .q     (sclk_q),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clock (clock),
    .reset (reset),
    .din   (cs_n),
    .q     (cs_q),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clock (clock),
    .reset (reset),
    .din   (mosi),
    .q     (mosi_q),
    .rise  (),
    .fall  ()
  );

  state_t                state;
  logic [4:0]            bit_cnt;
  logic [1:0]            load_cnt;
  logic [DATA_BITS-2:0]  shift_in;
  logic [DATA_BITS-1:0]  shift_out;
  logic                  write_req;
  logic                  over_seen;
  logic                  in_frame;

  assign fsm_state = state;
  assign in_frame  = (state == CMD) || (state == LOAD) || (state == DATA);

  always_ff @(posedge clock) begin
    if (reset) begin
      // Landing in DONE makes a frame already in flight be ignored; over_seen
      // set keeps its trailing clocks from counting as an over-length error.
      state         <= DONE;
      busy          <= 1'b1;
      bit_cnt       <= '0;
      load_cnt      <= '0;
      shift_in      <= '0;
      shift_out     <= '0;
      write_req     <= 1'b0;
      over_seen     <= 1'b1;
      miso          <= 1'b0;
      adr_out       <= '0;
      data_wr       <= '0;
      wr_enable     <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      wr_enable <= 1'b0;
      if (cs_rise && in_frame) begin
        // Chip select dropped mid-frame: abort, no write, count the error.
        state         <= IDLE;
        busy          <= 1'b0;
        miso          <= 1'b0;
        frame_err_cnt <= sat_inc(frame_err_cnt);
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              bit_cnt   <= '0;
              over_seen <= 1'b0;
              busy      <= 1'b1;
              state     <= CMD;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[DATA_BITS-3:0], mosi_q};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == CMD_LAST) begin
                write_req <= shift_in[6];
                adr_out   <= {1'b0, shift_in[5:0], mosi_q};
                load_cnt  <= '0;
                state     <= LOAD;
              end
            end
          end
          LOAD: begin
            if (load_cnt == LOAD_LAST) begin
              shift_out <= data_rd;
              state     <= DATA;
            end else begin
              load_cnt <= load_cnt + 2'd1;
            end
          end
          DATA: begin
            if (sclk_fall) begin
              miso      <= shift_out[DATA_BITS-1];
              shift_out <= {shift_out[DATA_BITS-2:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_in <= {shift_in[DATA_BITS-3:0], mosi_q};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == FRAME_LAST) begin
                data_wr <= {shift_in, mosi_q};
                miso    <= 1'b0;
                state   <= COMMIT;
              end
            end
          end
          COMMIT: begin
            wr_enable <= write_req;
            state     <= DONE;
          end
          DONE: begin
            miso <= 1'b0;
            if (cs_q) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (sclk_rise && !over_seen) begin
              over_seen     <= 1'b1;
              frame_err_cnt <= sat_inc(frame_err_cnt);
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: SPI master driver, bus-side register file,
// write/read scoreboard queues and per-scenario tests.
module tb_spi_reg_master;
  import spi_reg_master_pkg::*;

  localparam int HP = 80;  // SCLK half period = 8 system clocks

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk  = 1'b0;
  logic        cs_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic [7:0]  adr_out;
  logic [15:0] data_wr;
  logic        wr_enable;
  logic [15:0] data_rd = 16'h0000;
  logic [7:0]  frame_err_cnt;
  logic        busy;
  state_t      fsm_state;

  logic [15:0] regfile [0:255];
  logic [15:0] exp_mem [0:255];
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_err = 0;
  logic        prev_we = 1'b0;

  always #5 clock = ~clock;

  spi_reg_master #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
    .clock         (clock),
    .reset         (reset),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso),
    .adr_out       (adr_out),
    .data_wr       (data_wr),
    .wr_enable     (wr_enable),
    .data_rd       (data_rd),
    .frame_err_cnt (frame_err_cnt),
    .busy          (busy),
    .fsm_state     (fsm_state)
  );

  // Register file on the parallel bus: registered read, write on strobe.
  always @(posedge clock) begin
    if (wr_enable) regfile[adr_out] <= data_wr;
    data_rd <= regfile[adr_out];
  end

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (wr_enable) begin
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got adr=%h data=%h, required no write", adr_out, data_wr);
      end else begin
        logic [23:0] exp;
        exp = exp_wr_q.pop_front();
        if ({adr_out, data_wr} !== exp) begin
          n_err++;
          $display("FAIL wr_value: got adr=%h data=%h, required adr=%h data=%h",
                   adr_out, data_wr, exp[23:16], exp[15:0]);
        end
      end
      n_cmp++;
      if (prev_we !== 1'b0) begin
        n_err++;
        $display("FAIL wr_width: strobe high for more than one clock, required 1");
      end
    end
    prev_we = wr_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic spi_start();
    cs_n = 1'b0;
    #HP;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #HP;
    sclk = 1'b1;
    m = miso;
    #HP;
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    #HP;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(2 * HP);
  endtask

  task automatic spi_frame(input logic [23:0] f, input int nbits, output logic [23:0] rx);
    logic m;
    rx = '0;
    spi_start();
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 24) ? f[23 - i] : 1'b0, m);
      if (i < 24) rx[23 - i] = m;
    end
    spi_end();
  endtask

  // Push what a completing frame must produce: old register value on MISO
  // and, for writes, one bus write.
  task automatic expect_frame(input logic [23:0] f);
    logic [7:0] a;
    a = {1'b0, f[22:16]};
    exp_rd_q.push_back(exp_mem[a]);
    if (f[23]) begin
      exp_wr_q.push_back({a, f[15:0]});
      exp_mem[a] = f[15:0];
    end
  endtask

  function automatic int sat_err(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (adr_out !== 8'h00) begin n_err++; $display("FAIL rst_adr: got %h required 00", adr_out); end
    n_cmp++; if (data_wr !== 16'h0000) begin n_err++; $display("FAIL rst_data_wr: got %h required 0000", data_wr); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b required 0", wr_enable); end
    n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL rst_miso: got %b required 0", miso); end
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err: got %0d required 0", frame_err_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b required 1", busy); end
    n_cmp++; if (fsm_state !== DONE) begin n_err++; $display("FAIL rst_state: got %0d required %0d", fsm_state, DONE); end
    reset = 1'b0;
    repeat (8) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b required 0", busy); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL rst_idle_state: got %0d required %0d", fsm_state, IDLE); end
  endtask

  task automatic test_read();
    logic [23:0] rx;
    logic [15:0] exp;
    expect_frame(24'h01_0000);
    spi_frame(24'h01_0000, 24, rx);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL read_miso: got %h required %h", rx[15:0], exp); end
    n_cmp++; if (rx[23:16] !== 8'h00) begin n_err++; $display("FAIL read_cmd_miso: got %h required 00", rx[23:16]); end
    n_cmp++; if (adr_out !== 8'h01) begin n_err++; $display("FAIL read_adr: got %h required 01", adr_out); end
  endtask

  task automatic test_write_read();
    logic [23:0] rx;
    logic [15:0] exp;
    expect_frame(24'h83_A5C3);
    spi_frame(24'h83_A5C3, 24, rx);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL wr_old_miso: got %h required %h", rx[15:0], exp); end
    n_cmp++; if (adr_out !== 8'h03) begin n_err++; $display("FAIL wr_adr_hold: got %h required 03", adr_out); end
    n_cmp++; if (data_wr !== 16'hA5C3) begin n_err++; $display("FAIL wr_data_hold: got %h required a5c3", data_wr); end
    n_cmp++; if (exp_wr_q.size() !== 0) begin n_err++; $display("FAIL wr_missing: got %0d pending required 0", exp_wr_q.size()); end
    expect_frame(24'h03_0000);
    spi_frame(24'h03_0000, 24, rx);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL readback_miso: got %h required %h", rx[15:0], exp); end
  endtask

  task automatic test_abort();
    logic [23:0] rx;
    logic [15:0] exp;
    spi_frame(24'h82_FFFF, 12, rx);
    exp_err = sat_err(exp_err);
    n_cmp++; if (frame_err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL abort_err: got %0d required %0d", frame_err_cnt, exp_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b required 0", busy); end
    expect_frame(24'h02_0000);
    spi_frame(24'h02_0000, 24, rx);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL abort_next_miso: got %h required %h", rx[15:0], exp); end
    n_cmp++; if (frame_err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL abort_next_err: got %0d required %0d", frame_err_cnt, exp_err); end
  endtask

  task automatic test_over_length();
    logic [23:0] rx;
    logic [15:0] exp;
    expect_frame(24'h80_1234);
    spi_frame(24'h80_1234, 30, rx);
    exp_err = sat_err(exp_err);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL ovl_miso: got %h required %h", rx[15:0], exp); end
    n_cmp++; if (frame_err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL ovl_err: got %0d required %0d", frame_err_cnt, exp_err); end
    n_cmp++; if (exp_wr_q.size() !== 0) begin n_err++; $display("FAIL ovl_missing_wr: got %0d pending required 0", exp_wr_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] f;
    logic [23:0] rx;
    logic [15:0] exp;
    logic        m;
    f = 24'h85_1111;
    spi_start();
    for (int i = 0; i < 18; i++) spi_bit(f[23 - i], m);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (adr_out !== 8'h00) begin n_err++; $display("FAIL mrst_adr: got %h required 00", adr_out); end
    n_cmp++; if (data_wr !== 16'h0000) begin n_err++; $display("FAIL mrst_data_wr: got %h required 0000", data_wr); end
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL mrst_err: got %0d required 0", frame_err_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mrst_busy: got %b required 1", busy); end
    reset = 1'b0;
    exp_err = 0;
    for (int i = 18; i < 24; i++) spi_bit(f[23 - i], m);
    n_cmp++; if (fsm_state !== DONE) begin n_err++; $display("FAIL mrst_wait_state: got %0d required %0d", fsm_state, DONE); end
    n_cmp++; if (frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL mrst_tail_err: got %0d required 0", frame_err_cnt); end
    spi_end();
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL mrst_idle: got %0d required %0d", fsm_state, IDLE); end
    expect_frame(24'h05_0000);
    spi_frame(24'h05_0000, 24, rx);
    exp = exp_rd_q.pop_front();
    n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL mrst_next_miso: got %h required %h", rx[15:0], exp); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] f;
    logic [23:0] rx;
    logic [15:0] exp;
    for (int n = 0; n < 12; n++) begin
      f = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 16'($urandom_range(0, 65535))};
      if (!f[23]) f[15:0] = 16'h0000;
      expect_frame(f);
      spi_frame(f, 24, rx);
      exp = exp_rd_q.pop_front();
      n_cmp++; if (rx[15:0] !== exp) begin n_err++; $display("FAIL b2b_miso[%0d]: frame %h got %h required %h", n, f, rx[15:0], exp); end
    end
    n_cmp++; if (frame_err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL b2b_err: got %0d required %0d", frame_err_cnt, exp_err); end
  endtask

  task automatic test_saturation();
    logic [23:0] rx;
    for (int n = 0; n < 300; n++) begin
      spi_frame(24'h82_FFFF, $urandom_range(0, 3), rx);
      exp_err = sat_err(exp_err);
      if (n == 99) begin
        n_cmp++; if (frame_err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL sat_mid: got %0d required %0d", frame_err_cnt, exp_err); end
      end
    end
    n_cmp++; if (frame_err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d required 255", frame_err_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      regfile[i] = 16'h0000;
      exp_mem[i] = 16'h0000;
    end
    regfile[1] = 16'h0020;
    exp_mem[1] = 16'h0020;
    test_reset();
    test_read();
    test_write_read();
    test_abort();
    test_over_length();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    n_cmp++; if (exp_wr_q.size() !== 0) begin n_err++; $display("FAIL end_wr_pending: got %0d required 0", exp_wr_q.size()); end
    n_cmp++; if (exp_rd_q.size() !== 0) begin n_err++; $display("FAIL end_rd_pending: got %0d required 0", exp_rd_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
